// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned PC_W    = 32;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef logic [INSTR_W-1:0] instr_t;
   typedef logic [PC_W-1:0]    pc_t;

   typedef struct packed {
      logic   valid;
      instr_t instr;
      pc_t    pc;
      pc_t    pc_next;
   } if_id_t;

endpackage

// File: rtl/if_instr_rom.sv
// Word-indexed instruction ROM with combinational read; preloaded with NOPs.
module if_instr_rom
   import if_pkg::*;
#(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned DEPTH     = 256,
   parameter string       INIT_FILE = ""
) (
   input  logic [$clog2(DEPTH)-1:0] i_addr,
   output logic [WIDTH-1:0]         o_data
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   // ROM image: defaults to NOP so unloaded words decode harmlessly
   initial begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] = WIDTH'(NOP_INSTR);
   end

   assign o_data = r_mem[i_addr];

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, ROM lookup and registered IF/ID output with
// valid/ready handshake, redirect flush and stall. IF_MISALIGN_CHECK_EN adds
// the misaligned-redirect flag and port.
module if_fetch_stage
   import if_pkg::*;
#(
   parameter int unsigned          INSTR_WIDTH     = 32,
   parameter int unsigned          PC_WIDTH        = 32,
   parameter int unsigned          INSTR_MEM_DEPTH = 256,
   parameter logic [PC_WIDTH-1:0]  RESET_VECTOR    = '0,
   parameter string                INIT_FILE       = ""
) (
   input  logic                   i_clk,
   input  logic                   i_reset_n,
   input  logic                   i_redirect_valid,
   input  logic [PC_WIDTH-1:0]    i_redirect_pc,
   input  logic                   i_ID_ready,
   output logic                   o_IF_valid,
   output logic [INSTR_WIDTH-1:0] o_IF_instr,
   output logic [PC_WIDTH-1:0]    o_IF_pc,
   output logic [PC_WIDTH-1:0]    o_IF_pc_next
`ifdef IF_MISALIGN_CHECK_EN
   ,
   output logic                   o_IF_misaligned
`endif
);

   localparam int unsigned ADDR_BITS = $clog2(INSTR_MEM_DEPTH);

   typedef struct packed {
      logic                   valid;
      logic [INSTR_WIDTH-1:0] instr;
      logic [PC_WIDTH-1:0]    pc;
      logic [PC_WIDTH-1:0]    pc_next;
   } if_out_t;

   logic [PC_WIDTH-1:0]    r_pc;
   logic [PC_WIDTH-1:0]    w_pc_nxt;
   logic [PC_WIDTH-1:0]    w_pc_plus4;
   logic [INSTR_WIDTH-1:0] w_rom_data;
   logic                   w_advance;
   if_out_t                r_out;
   if_out_t                w_out_nxt;

`ifdef IF_MISALIGN_CHECK_EN
   logic r_mis_pend;
   logic w_mis_pend_nxt;
   logic r_out_mis;
   logic w_out_mis_nxt;
`endif

   if_instr_rom #(
      .WIDTH     (INSTR_WIDTH),
      .DEPTH     (INSTR_MEM_DEPTH),
      .INIT_FILE (INIT_FILE)
   ) u_rom (
      .i_addr (r_pc[ADDR_BITS+1:2]),
      .o_data (w_rom_data)
   );

   assign w_pc_plus4 = r_pc + PC_WIDTH'(4);
   assign w_advance  = !r_out.valid || i_ID_ready;

   // Next state: redirect beats advance; otherwise everything holds (stall)
   always_comb begin
      w_pc_nxt  = r_pc;
      w_out_nxt = r_out;
`ifdef IF_MISALIGN_CHECK_EN
      w_mis_pend_nxt = r_mis_pend;
      w_out_mis_nxt  = r_out_mis;
`endif
      if (i_redirect_valid) begin
         w_pc_nxt        = i_redirect_pc;
         w_out_nxt.valid = 1'b0;
         w_out_nxt.instr = INSTR_WIDTH'(NOP_INSTR);
`ifdef IF_MISALIGN_CHECK_EN
         w_mis_pend_nxt = |i_redirect_pc[1:0];
         w_out_mis_nxt  = 1'b0;
`endif
      end else if (w_advance) begin
         w_out_nxt.valid   = 1'b1;
         w_out_nxt.instr   = w_rom_data;
         w_out_nxt.pc      = r_pc;
         w_out_nxt.pc_next = w_pc_plus4;
         w_pc_nxt          = w_pc_plus4;
`ifdef IF_MISALIGN_CHECK_EN
         // A pending misaligned target is emitted once as a flagged NOP
         if (r_mis_pend) w_out_nxt.instr = INSTR_WIDTH'(NOP_INSTR);
         w_out_mis_nxt  = r_mis_pend;
         w_mis_pend_nxt = 1'b0;
`endif
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_pc          <= RESET_VECTOR;
         r_out.valid   <= 1'b0;
         r_out.instr   <= INSTR_WIDTH'(NOP_INSTR);
         r_out.pc      <= '0;
         r_out.pc_next <= '0;
      end else begin
         r_pc  <= w_pc_nxt;
         r_out <= w_out_nxt;
      end
   end

`ifdef IF_MISALIGN_CHECK_EN
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_mis_pend <= 1'b0;
         r_out_mis  <= 1'b0;
      end else begin
         r_mis_pend <= w_mis_pend_nxt;
         r_out_mis  <= w_out_mis_nxt;
      end
   end

   assign o_IF_misaligned = r_out_mis;
`endif

   assign o_IF_valid   = r_out.valid;
   assign o_IF_instr   = r_out.instr;
   assign o_IF_pc      = r_out.pc;
   assign o_IF_pc_next = r_out.pc_next;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a 32-bit-PC instance (reset vector 0x40)
// and an 8-bit-PC instance that exercises PC and ROM-index wrap.
module tb_if_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        redir_a;
   logic [31:0] redir_pc_a;
   logic        ready_a;

   logic        a_valid;
   logic [31:0] a_instr;
   logic [31:0] a_pc;
   logic [31:0] a_pc_next;
   logic        b_valid;
   logic [31:0] b_instr;
   logic [7:0]  b_pc;
   logic [7:0]  b_pc_next;
`ifdef IF_MISALIGN_CHECK_EN
   logic        a_mis;
   logic        b_mis;
`endif

   logic [31:0] rom_a [256];
   logic [31:0] rom_b [64];

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   if_fetch_stage #(
      .INSTR_WIDTH(32), .PC_WIDTH(32), .INSTR_MEM_DEPTH(256),
      .RESET_VECTOR(32'h40), .INIT_FILE("")
   ) dut_a (
      .i_clk            (clk),
      .i_reset_n        (reset_n),
      .i_redirect_valid (redir_a),
      .i_redirect_pc    (redir_pc_a),
      .i_ID_ready       (ready_a),
      .o_IF_valid       (a_valid),
      .o_IF_instr       (a_instr),
      .o_IF_pc          (a_pc),
      .o_IF_pc_next     (a_pc_next)
`ifdef IF_MISALIGN_CHECK_EN
      , .o_IF_misaligned (a_mis)
`endif
   );

   if_fetch_stage #(
      .INSTR_WIDTH(32), .PC_WIDTH(8), .INSTR_MEM_DEPTH(64),
      .RESET_VECTOR(8'hF8), .INIT_FILE("")
   ) dut_b (
      .i_clk            (clk),
      .i_reset_n        (reset_n),
      .i_redirect_valid (1'b0),
      .i_redirect_pc    (8'h00),
      .i_ID_ready       (1'b1),
      .o_IF_valid       (b_valid),
      .o_IF_instr       (b_instr),
      .o_IF_pc          (b_pc),
      .o_IF_pc_next     (b_pc_next)
`ifdef IF_MISALIGN_CHECK_EN
      , .o_IF_misaligned (b_mis)
`endif
   );

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_a(input string tag, input logic v, input logic [31:0] ins,
                          input logic [31:0] pc, input logic [31:0] pcn);
      check_eq({tag, ".valid"},   64'(a_valid),   64'(v));
      check_eq({tag, ".instr"},   64'(a_instr),   64'(ins));
      check_eq({tag, ".pc"},      64'(a_pc),      64'(pc));
      check_eq({tag, ".pc_next"}, 64'(a_pc_next), 64'(pcn));
   endtask

   initial begin
      reset_n    = 1'b0;
      redir_a    = 1'b0;
      redir_pc_a = 32'h0;
      ready_a    = 1'b1;

      // Distinct words everywhere so a wrong index is visible
      for (int i = 0; i < 256; i++) rom_a[i] = 32'hA000_0000 + 32'(i);
      rom_a[16] = 32'h0010_0093;
      rom_a[17] = 32'h0020_0113;
      for (int i = 0; i < 64; i++) rom_b[i] = 32'hB000_0000 + 32'(i);
      #1;
      for (int i = 0; i < 256; i++) dut_a.u_rom.r_mem[i] = rom_a[i];
      for (int i = 0; i < 64; i++)  dut_b.u_rom.r_mem[i] = rom_b[i];

      tick();
      tick();
      check_a("reset", 1'b0, NOP, 32'h0, 32'h0);
      check_eq("b_reset.valid", 64'(b_valid), 64'(0));

      reset_n = 1'b1;
      tick();
      check_a("first", 1'b1, 32'h0010_0093, 32'h40, 32'h44);
      check_eq("b_f8.pc",    64'(b_pc),      64'(8'hF8));
      check_eq("b_f8.instr", 64'(b_instr),   64'(rom_b[62]));
      tick();
      check_a("second", 1'b1, 32'h0020_0113, 32'h44, 32'h48);
      check_eq("b_fc.pc",      64'(b_pc),      64'(8'hFC));
      check_eq("b_fc.pc_next", 64'(b_pc_next), 64'(8'h00));
      check_eq("b_fc.instr",   64'(b_instr),   64'(rom_b[63]));

      ready_a = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_a("stall", 1'b1, 32'h0020_0113, 32'h44, 32'h48);
         if (i == 0) begin
            check_eq("b_wrap.pc",      64'(b_pc),      64'(8'h00));
            check_eq("b_wrap.pc_next", 64'(b_pc_next), 64'(8'h04));
            check_eq("b_wrap.instr",   64'(b_instr),   64'(rom_b[0]));
         end
      end
      ready_a = 1'b1;
      tick();
      check_a("resume", 1'b1, rom_a[18], 32'h48, 32'h4C);
      tick();
      check_a("run4c", 1'b1, rom_a[19], 32'h4C, 32'h50);

      redir_a    = 1'b1;
      redir_pc_a = 32'h80;
      tick();
      check_a("redir_bubble", 1'b0, NOP, 32'h4C, 32'h50);
      redir_a = 1'b0;
      tick();
      check_a("redir_target", 1'b1, rom_a[32], 32'h80, 32'h84);

      ready_a = 1'b0;
      tick();
      check_a("stall80", 1'b1, rom_a[32], 32'h80, 32'h84);
      redir_a    = 1'b1;
      redir_pc_a = 32'h100;
      tick();
      check_a("flush_stall", 1'b0, NOP, 32'h80, 32'h84);
      redir_a = 1'b0;
      tick();
      check_a("tgt100", 1'b1, rom_a[64], 32'h100, 32'h104);
      tick();
      check_a("hold100", 1'b1, rom_a[64], 32'h100, 32'h104);
      ready_a = 1'b1;
      tick();
      check_a("run104", 1'b1, rom_a[65], 32'h104, 32'h108);

`ifdef IF_MISALIGN_CHECK_EN
      redir_a    = 1'b1;
      redir_pc_a = 32'h82;
      tick();
      check_a("mis_bubble", 1'b0, NOP, 32'h104, 32'h108);
      check_eq("mis_bubble.flag", 64'(a_mis), 64'(0));
      redir_a = 1'b0;
      tick();
      check_a("mis_emit", 1'b1, NOP, 32'h82, 32'h86);
      check_eq("mis_emit.flag", 64'(a_mis), 64'(1));
      tick();
      check_a("mis_after", 1'b1, rom_a[33], 32'h86, 32'h8A);
      check_eq("mis_after.flag", 64'(a_mis), 64'(0));
`endif

      // Reset while stalled discards everything and restarts at the vector
      ready_a = 1'b0;
      tick();
      reset_n = 1'b0;
      tick();
      check_a("reset_stall", 1'b0, NOP, 32'h0, 32'h0);
      reset_n = 1'b1;
      ready_a = 1'b1;
      tick();
      check_a("restart", 1'b1, 32'h0010_0093, 32'h40, 32'h44);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
